sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Two-requester front end that sits directly upstream of the ordinary data SRAM.
- Arbitrates round-robin between requester 0 (load/store unit) and requester 1 (PTW/debug).
- Converts valid/ready request channels into the SRAM's single-cycle req/we/addr/be/wdata/pc interface.
- Captures the SRAM's registered-address read data, and returns in-order, ID-routed responses through a small response FIFO.
- Carries a *_t0 taint shadow on every data-bearing signal, for IFT verification.

Parameters:
- DATA_WIDTH, 64, SRAM word width
- NUM_BYTES, 8, byte enables per word (DATA_WIDTH/8)
- ADDR_WIDTH, 16, SRAM word-address width
- VLEN, 64, PC width forwarded to the SRAM
- ADDR_LIMIT, 31, highest legal word address; larger addresses are rejected
- RSP_DEPTH, 2, response FIFO entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-requester request valid
- req_ready_o  out  2  per-requester request accept
- req_we_i  in  2  per-requester write enable
- req_addr_i  in  2×ADDR_WIDTH  word address
- req_wdata_i  in  2×DATA_WIDTH  write data
- req_be_i  in  2×NUM_BYTES  byte enables
- req_pc_i  in  2×VLEN  PC of originating instruction
- req_{valid,we,addr,wdata,be,pc}_i_t0  in  same widths  taint of each request field
- rsp_valid_o  out  2  per-requester response valid
- rsp_ready_i  in  2  per-requester response accept
- rsp_rdata_o  out  DATA_WIDTH  response data (shared bus, qualified by rsp_valid_o)
- rsp_err_o  out  1  address-range error
- rsp_rdata_o_t0  out  DATA_WIDTH  response data taint
- sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, sram_pc_o  out  SRAM widths  to SRAM
- sram_{req,we,addr,wdata,be,pc}_o_t0  out  same  taint to SRAM
- sram_rdata_i, sram_rdata_i_t0  in  DATA_WIDTH  from SRAM

Behaviour:
Reset
- Asynchronous, active-low. Clears FIFO pointers/count, inflight flag, inflight id/err, and the RR pointer (which resets to point at requester 0).
- All *_valid_o, req_ready_o, sram_req_o and every *_t0 output are 0 during reset.
- Reset mid-operation silently drops an inflight read and all queued responses.

Credit
- credit_ok = (fifo_count + inflight) < RSP_DEPTH.
- A pop in the same cycle does not free a credit (no bypass).
- req_ready_o[n] = credit_ok & grant[n].

Arbitration
- Combinational round-robin over req_valid_i. The RR pointer starts at 0.
- The RR pointer moves past the winner only on a handshake.
- Exactly one grant per cycle, and only when credit_ok.

Issue (cycle N)
- On handshake with addr ≤ ADDR_LIMIT: sram_req_o=1, and we/addr/wdata/be/pc are muxed from the winner in the same cycle (zero-latency).
- If addr > ADDR_LIMIT: sram_req_o stays 0, and an error entry is still booked (inflight=1, err=1).
- inflight, inflight_id and inflight_err are registered.

Capture (cycle N+1)
- When inflight is set, enqueue {id, err, rdata, rdata_t0}:
  - read: rdata = sram_rdata_i, rdata_t0 = sram_rdata_i_t0;
  - write or error: rdata = 0, rdata_t0 = 0.
- Writes also produce an ack response, so ordering is uniform.

Response
- FIFO head drives rsp_valid_o[head.id] only. Pop on rsp_valid_o & rsp_ready_i of that id.
- Strictly in-order; a stalled requester blocks the other (head-of-line blocking by design).
- Pointers wrap modulo RSP_DEPTH. Full (count=RSP_DEPTH) is unreachable by the credit rule; an assertion checks this.

Taint
- Each sram_*_o_t0 = the winner's field taint, OR-reduced with the loser's req_valid_i_t0 (grant-decision taint).
- sram_req_o_t0 = |req_valid_i_t0.
- rsp_valid_o_t0 is not produced.
- rsp_rdata_o_t0 comes from the FIFO entry, ORed with the entry's stored address-taint reduction for reads.

Decomposition:
- Shared package sram_arb_pkg:
  - rsp_entry_t {logic id; logic err; logic [DATA_WIDTH-1:0] rdata, rdata_t0; logic addr_tainted};
  - REQ_ID_W = 1.
- One sub-module: sram_rsp_fifo, a generic RSP_DEPTH FIFO of rsp_entry_t with count output. Arbiter and capture logic stay in the top.

Test Plan:
- Single read: preload word 5 = 0xDEADBEEF_01234567; req0 read addr 5.
  → sram_req_o in cycle N; rsp_valid_o=2'b01 at N+2 earliest, data matches, err=0.
- Contention: both valid every cycle, rsp_ready=11.
  → grants alternate 0,1,0,1; responses return in issue order with correct ids.
- Backpressure: rsp_ready_i=00, three back-to-back reads.
  → third req_ready_o held 0 until a pop; no response lost or duplicated.
- Out-of-range: req1 write addr 40.
  → no sram_req_o; rsp_valid_o=2'b10 with err=1, rdata=0.
- Taint: req0 read addr 3 with req_addr_i_t0=1.
  → sram_addr_o_t0 nonzero, and rsp_rdata_o_t0 nonzero.
- Taint, untainted case: write with wdata_t0=0, then read-back.
  → rsp_rdata_o_t0=0.
- Reset during inflight read: assert rst_ni low at N+1.
  → no rsp_valid_o after release; RR pointer at 0; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM port arbiter
package sram_arb_pkg;

    localparam int DATA_W   = 64;
    localparam int REQ_ID_W = 1;

    typedef struct packed {
        logic [REQ_ID_W-1:0] id;
        logic                err;
        logic [DATA_W-1:0]   rdata;
        logic [DATA_W-1:0]   rdata_t0;
        logic                addr_tainted;
    } rsp_entry_t;

    function automatic logic [1:0] id_onehot(input logic [REQ_ID_W-1:0] id);
        return id[0] ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - in-order response FIFO of rsp_entry_t with occupancy count
module sram_rsp_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  rsp_entry_t    push_data,
    input  logic          pop,
    output rsp_entry_t    head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    rsp_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester round-robin front end for the data SRAM with taint shadow
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int NUM_BYTES  = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 16,
    parameter int VLEN       = 64,
    parameter int ADDR_LIMIT = 31,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 req_valid_i,
    output logic [1:0]                 req_ready_o,
    input  logic [1:0]                 req_we_i,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0][NUM_BYTES-1:0]  req_be_i,
    input  logic [1:0][VLEN-1:0]       req_pc_i,
    input  logic [1:0]                 req_valid_i_t0,
    input  logic [1:0]                 req_we_i_t0,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i_t0,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata_i_t0,
    input  logic [1:0][NUM_BYTES-1:0]  req_be_i_t0,
    input  logic [1:0][VLEN-1:0]       req_pc_i_t0,
    output logic [1:0]                 rsp_valid_o,
    input  logic [1:0]                 rsp_ready_i,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic [DATA_WIDTH-1:0]      rsp_rdata_o_t0,
    output logic                       sram_req_o,
    output logic                       sram_we_o,
    output logic [ADDR_WIDTH-1:0]      sram_addr_o,
    output logic [DATA_WIDTH-1:0]      sram_wdata_o,
    output logic [NUM_BYTES-1:0]       sram_be_o,
    output logic [VLEN-1:0]            sram_pc_o,
    output logic                       sram_req_o_t0,
    output logic                       sram_we_o_t0,
    output logic [ADDR_WIDTH-1:0]      sram_addr_o_t0,
    output logic [DATA_WIDTH-1:0]      sram_wdata_o_t0,
    output logic [NUM_BYTES-1:0]       sram_be_o_t0,
    output logic [VLEN-1:0]            sram_pc_o_t0,
    input  logic [DATA_WIDTH-1:0]      sram_rdata_i,
    input  logic [DATA_WIDTH-1:0]      sram_rdata_i_t0
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          rr_q;
    logic          inflight_q;
    logic          infl_id_q;
    logic          infl_err_q;
    logic          infl_rd_q;
    logic          infl_at_q;

    logic [1:0]    grant;
    logic          win;
    logic          hs;
    logic          addr_ok;
    logic          lvt;
    logic          credit_ok;

    logic [CW-1:0] fifo_count;
    rsp_entry_t    fifo_head;
    rsp_entry_t    push_entry;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;

    // The inflight slot holds a credit until its entry lands in the FIFO; pops never bypass.
    assign credit_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(RSP_DEPTH);

    always_comb begin
        grant = 2'b00;
        if (rst_ni && credit_ok) begin
            if (req_valid_i[rr_q])       grant[rr_q]  = 1'b1;
            else if (req_valid_i[~rr_q]) grant[~rr_q] = 1'b1;
        end
    end

    assign win         = grant[1];
    assign hs          = |grant;
    assign req_ready_o = grant;
    assign addr_ok     = (req_addr_i[win] <= ADDR_WIDTH'(ADDR_LIMIT));
    assign lvt         = req_valid_i_t0[~win];

    assign sram_req_o    = hs & addr_ok;
    assign sram_req_o_t0 = rst_ni & (|req_valid_i_t0);

    // Each forwarded field's taint also carries the loser's valid taint: it steered the grant.
    always_comb begin
        sram_we_o       = 1'b0;
        sram_addr_o     = '0;
        sram_wdata_o    = '0;
        sram_be_o       = '0;
        sram_pc_o       = '0;
        sram_we_o_t0    = 1'b0;
        sram_addr_o_t0  = '0;
        sram_wdata_o_t0 = '0;
        sram_be_o_t0    = '0;
        sram_pc_o_t0    = '0;
        if (hs) begin
            sram_we_o       = req_we_i[win];
            sram_addr_o     = req_addr_i[win];
            sram_wdata_o    = req_wdata_i[win];
            sram_be_o       = req_be_i[win];
            sram_pc_o       = req_pc_i[win];
            sram_we_o_t0    = req_we_i_t0[win] | lvt;
            sram_addr_o_t0  = req_addr_i_t0[win] | {ADDR_WIDTH{lvt}};
            sram_wdata_o_t0 = req_wdata_i_t0[win] | {DATA_WIDTH{lvt}};
            sram_be_o_t0    = req_be_i_t0[win] | {NUM_BYTES{lvt}};
            sram_pc_o_t0    = req_pc_i_t0[win] | {VLEN{lvt}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= 1'b0;
            inflight_q <= 1'b0;
            infl_id_q  <= 1'b0;
            infl_err_q <= 1'b0;
            infl_rd_q  <= 1'b0;
            infl_at_q  <= 1'b0;
        end else begin
            inflight_q <= hs;
            if (hs) begin
                rr_q       <= ~win;
                infl_id_q  <= win;
                infl_err_q <= ~addr_ok;
                infl_rd_q  <= addr_ok & ~req_we_i[win];
                infl_at_q  <= |sram_addr_o_t0;
            end
        end
    end

    // Writes and range errors return a zero-data ack so every request yields one response.
    always_comb begin
        push_entry              = '0;
        push_entry.id           = infl_id_q;
        push_entry.err          = infl_err_q;
        push_entry.rdata        = infl_rd_q ? sram_rdata_i : '0;
        push_entry.rdata_t0     = infl_rd_q ? sram_rdata_i_t0 : '0;
        push_entry.addr_tainted = infl_rd_q & infl_at_q;
    end

    assign fifo_push = inflight_q;

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rsp_valid_o    = fifo_empty ? 2'b00 : id_onehot(fifo_head.id);
    assign fifo_pop       = |(rsp_valid_o & rsp_ready_i);
    assign rsp_err_o      = ~fifo_empty & fifo_head.err;
    assign rsp_rdata_o    = fifo_empty ? '0 : fifo_head.rdata;
    assign rsp_rdata_o_t0 = fifo_empty ? '0
                          : (fifo_head.rdata_t0 | {DATA_WIDTH{fifo_head.addr_tainted}});

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fifo_push && fifo_full));

endmodule
